// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants, fetch-state encoding and F/D payload type for the fetch PC unit.
package fetch_pc_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned EXC_W  = 5;
    localparam int unsigned FSM_W  = 2;

    localparam logic [XLEN-1:0] PC_RESET_C   = 32'h0000_3000;
    localparam logic [XLEN-1:0] EXC_VECTOR_C = 32'h0000_4180;
    localparam logic [XLEN-1:0] IM_LO_C      = 32'h0000_3000;
    localparam logic [XLEN-1:0] IM_HI_C      = 32'h0000_6ffc;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

    typedef enum logic [FSM_W-1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_REDIR = 2'd2
    } fstate_e;

    // Contents of the F/D pipeline register
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic             valid;
        logic             bd;
        logic [EXC_W-1:0] exc;
    } fd_reg_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control inputs and F/D outputs of the fetch PC unit.
interface fetch_pc_if;
    import fetch_pc_unit_pkg::*;

    logic [XLEN-1:0]  npc;
    logic [XLEN-1:0]  instr_in;
    logic             stall;
    logic             flush_req;
    logic             eret;
    logic [XLEN-1:0]  epc;
    logic             d_is_branch;
    logic [XLEN-1:0]  f_pc;
    logic [XLEN-1:0]  d_pc;
    logic [XLEN-1:0]  d_instr;
    logic             d_valid;
    logic             d_bd;
    logic [EXC_W-1:0] d_exc;
    logic [FSM_W-1:0] fstate;
    logic [XLEN-1:0]  fetch_cnt;

    modport master (
        output npc, instr_in, stall, flush_req, eret, epc, d_is_branch,
        input  f_pc, d_pc, d_instr, d_valid, d_bd, d_exc, fstate, fetch_cnt
    );

    modport slave (
        input  npc, instr_in, stall, flush_req, eret, epc, d_is_branch,
        output f_pc, d_pc, d_instr, d_valid, d_bd, d_exc, fstate, fetch_cnt
    );

endinterface

// File: rtl/fetch_pc_unit_pc_range_chk.sv
// Fetch-address alignment and instruction-memory range check (AdEL flag).
module pc_range_chk
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] IM_LO = IM_LO_C,
    parameter logic [XLEN-1:0] IM_HI = IM_HI_C
) (
    input  logic [XLEN-1:0] pc,
    output logic            adel_c
);

    always_comb begin
        adel_c = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register and F/D pipeline register with stall, flush, ERET redirect and AdEL tagging.
// Build option: define FETCH_CNT_EN to get the fetch_cnt counter; otherwise fetch_cnt reads 0.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET   = PC_RESET_C,
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_C,
    parameter logic [XLEN-1:0] IM_LO      = IM_LO_C,
    parameter logic [XLEN-1:0] IM_HI      = IM_HI_C
) (
    input  logic       clk,
    input  logic       reset,
    fetch_pc_if.slave  bus
);

    fstate_e         state_q, state_d;
    logic [XLEN-1:0] f_pc_q, f_pc_d;
    fd_reg_t         fd_q, fd_d;
    logic            adel_c;

    pc_range_chk #(
        .IM_LO (IM_LO),
        .IM_HI (IM_HI)
    ) u_range_chk (
        .pc     (f_pc_q),
        .adel_c (adel_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next F_PC / F/D contents; redirects beat stall
    always_comb begin
        state_d = state_q;
        f_pc_d  = f_pc_q;
        fd_d    = fd_q;

        if (bus.flush_req) begin
            state_d  = S_REDIR;
            f_pc_d   = EXC_VECTOR;
            fd_d     = '0;
            fd_d.pc  = EXC_VECTOR;
        end else if (bus.eret) begin
            state_d  = S_REDIR;
            f_pc_d   = bus.epc;
            fd_d     = '0;
            fd_d.pc  = bus.epc;
        end else if (bus.stall) begin
            state_d  = S_STALL;
        end else begin
            state_d     = S_RUN;
            f_pc_d      = bus.npc;
            fd_d.pc     = f_pc_q;
            fd_d.valid  = 1'b1;
            fd_d.bd     = bus.d_is_branch;
            fd_d.instr  = adel_c ? '0 : bus.instr_in;
            fd_d.exc    = adel_c ? EXC_ADEL : EXC_NONE;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q <= PC_RESET;
            fd_q   <= '0;
        end else begin
            f_pc_q <= f_pc_d;
            fd_q   <= fd_d;
        end
    end

`ifdef FETCH_CNT_EN
    logic [XLEN-1:0] cnt_q;
    logic            capture_c;

    assign capture_c = ~(bus.flush_req | bus.eret | bus.stall);

    // Counts valid F/D captures, wrapping naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (capture_c) begin
            cnt_q <= cnt_q + XLEN'(1);
        end
    end

    assign bus.fetch_cnt = cnt_q;
`else
    assign bus.fetch_cnt = '0;
`endif

    assign bus.f_pc    = f_pc_q;
    assign bus.d_pc    = fd_q.pc;
    assign bus.d_instr = fd_q.instr;
    assign bus.d_valid = fd_q.valid;
    assign bus.d_bd    = fd_q.bd;
    assign bus.d_exc   = fd_q.exc;
    assign bus.fstate  = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard testbench for fetch_pc_unit: a reference model pushes expected state per edge.
module tb_fetch_pc_unit;

    logic clk;
    logic reset;
    fetch_pc_if bus ();

    fetch_pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory image
    assign bus.instr_in = bus.f_pc ^ 32'h5a5a_0000;

    typedef struct {
        logic [31:0] f_pc;
        logic [31:0] d_pc;
        logic [31:0] d_instr;
        logic        d_valid;
        logic        d_bd;
        logic [4:0]  d_exc;
        logic [1:0]  fstate;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic bad_addr(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6ffc);
    endfunction

    // Drive one cycle of stimulus, predict the edge, then compare after it
    task automatic cycle(input logic rst, input logic [31:0] npc, input logic stl,
                         input logic fl, input logic er, input logic [31:0] epc,
                         input logic br);
        exp_t e;
        reset           = rst;
        bus.npc         = npc;
        bus.stall       = stl;
        bus.flush_req   = fl;
        bus.eret        = er;
        bus.epc         = epc;
        bus.d_is_branch = br;

        e = m;
        if (rst) begin
            e.f_pc = 32'h0000_3000; e.d_pc = '0; e.d_instr = '0;
            e.d_valid = 1'b0; e.d_bd = 1'b0; e.d_exc = '0; e.fstate = 2'd0; e.cnt = '0;
        end else if (fl) begin
            e.f_pc = 32'h0000_4180; e.d_pc = 32'h0000_4180; e.d_instr = '0;
            e.d_valid = 1'b0; e.d_bd = 1'b0; e.d_exc = '0; e.fstate = 2'd2;
        end else if (er) begin
            e.f_pc = epc; e.d_pc = epc; e.d_instr = '0;
            e.d_valid = 1'b0; e.d_bd = 1'b0; e.d_exc = '0; e.fstate = 2'd2;
        end else if (stl) begin
            e.fstate = 2'd1;
        end else begin
            e.d_pc    = m.f_pc;
            e.d_valid = 1'b1;
            e.d_bd    = br;
            e.d_instr = bad_addr(m.f_pc) ? 32'h0 : (m.f_pc ^ 32'h5a5a_0000);
            e.d_exc   = bad_addr(m.f_pc) ? 5'd4 : 5'd0;
            e.f_pc    = npc;
            e.fstate  = 2'd0;
            e.cnt     = m.cnt + 32'd1;
        end
        m = e;
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq("f_pc",    bus.f_pc,    e.f_pc);
            check_eq("d_pc",    bus.d_pc,    e.d_pc);
            check_eq("d_instr", bus.d_instr, e.d_instr);
            check_eq("d_valid", 32'(bus.d_valid), 32'(e.d_valid));
            check_eq("d_bd",    32'(bus.d_bd),    32'(e.d_bd));
            check_eq("d_exc",   32'(bus.d_exc),   32'(e.d_exc));
            check_eq("fstate",  32'(bus.fstate),  32'(e.fstate));
`ifdef FETCH_CNT_EN
            check_eq("fetch_cnt", bus.fetch_cnt, e.cnt);
`else
            check_eq("fetch_cnt", bus.fetch_cnt, 32'h0);
`endif
        end
    endtask

    task automatic run(input logic [31:0] npc, input logic br);
        cycle(1'b0, npc, 1'b0, 1'b0, 1'b0, 32'h0, br);
    endtask

    initial begin
        logic [31:0] cnt_snap;
        m = '{default: '0};
        reset = 1'b1;
        bus.npc = '0; bus.stall = 1'b0; bus.flush_req = 1'b0;
        bus.eret = 1'b0; bus.epc = '0; bus.d_is_branch = 1'b0;

        // Reset
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("reset_f_pc", bus.f_pc, 32'h0000_3000);
        check_eq("reset_d_valid", 32'(bus.d_valid), 32'd0);

        // Sequential fetch
        run(m.f_pc + 32'd4, 1'b0);
        check_eq("seq_f_pc1", bus.f_pc, 32'h0000_3004);
        check_eq("seq_d_pc1", bus.d_pc, 32'h0000_3000);
        run(m.f_pc + 32'd4, 1'b0);
        check_eq("seq_f_pc2", bus.f_pc, 32'h0000_3008);

        // Two-cycle stall at 0x3008
        cnt_snap = bus.fetch_cnt;
        cycle(1'b0, 32'h0000_300c, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0000_300c, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("stall_f_pc", bus.f_pc, 32'h0000_3008);
        check_eq("stall_d_pc", bus.d_pc, 32'h0000_3004);
        check_eq("stall_fstate", 32'(bus.fstate), 32'd1);
        check_eq("stall_cnt", bus.fetch_cnt, cnt_snap);

        run(32'h0000_300c, 1'b0);
        run(32'h0000_3010, 1'b0);
        // Branch in D: instruction at 0x3010 is a delay slot
        run(32'h0000_3014, 1'b1);
        check_eq("bd_d_pc", bus.d_pc, 32'h0000_3010);
        check_eq("bd_flag", 32'(bus.d_bd), 32'd1);

        // Misaligned fetch
        run(32'h0000_3002, 1'b0);
        run(32'h0000_3018, 1'b0);
        check_eq("mis_exc", 32'(bus.d_exc), 32'd4);
        check_eq("mis_instr", bus.d_instr, 32'h0);

        // Out-of-range fetch
        run(32'h0000_7000, 1'b0);
        run(32'h0000_301c, 1'b0);
        check_eq("oor_exc", 32'(bus.d_exc), 32'd4);
        run(32'h0000_6ffc, 1'b0);
        run(32'h0000_3020, 1'b0);
        check_eq("hi_edge_exc", 32'(bus.d_exc), 32'd0);

        // flush + stall + eret together: flush wins
        cycle(1'b0, 32'h0000_3024, 1'b1, 1'b1, 1'b1, 32'h0000_3040, 1'b0);
        check_eq("flush_f_pc", bus.f_pc, 32'h0000_4180);
        check_eq("flush_valid", 32'(bus.d_valid), 32'd0);
        check_eq("flush_fstate", 32'(bus.fstate), 32'd2);
        run(32'h0000_4184, 1'b0);
        check_eq("redir_to_run", 32'(bus.fstate), 32'd0);

        // ERET
        cycle(1'b0, 32'h0000_4188, 1'b0, 1'b0, 1'b1, 32'h0000_3020, 1'b0);
        check_eq("eret_f_pc", bus.f_pc, 32'h0000_3020);
        check_eq("eret_d_pc", bus.d_pc, 32'h0000_3020);
        // S_REDIR with stall goes to S_STALL
        cycle(1'b0, 32'h0000_3024, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("redir_to_stall", 32'(bus.fstate), 32'd1);

        // Wrap-around passes through and is flagged
        run(32'hffff_fffc, 1'b0);
        run(32'h0000_0000, 1'b0);
        run(32'h0000_3000, 1'b0);
        check_eq("wrap_exc", 32'(bus.d_exc), 32'd4);

        // Reset while stalled
        cycle(1'b0, 32'h0000_3004, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_3004, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("rst_stall_f_pc", bus.f_pc, 32'h0000_3000);
        check_eq("rst_stall_fstate", 32'(bus.fstate), 32'd0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            logic [31:0] r_npc;
            logic [31:0] r_epc;
            r_npc = (($urandom_range(0, 7) == 0) ? $urandom() : (32'h0000_3000 + 32'($urandom_range(0, 4095)) * 32'd4));
            r_epc = 32'h0000_3000 + 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(0, 9) == 0);
            cycle(1'b0, r_npc, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, r_epc, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
